adder_tree_acc: RTL and testbench
=================================

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 SHALL have parameter N_IN, default 8, number of input lanes; power of two, 2..64.
REQ-002 SHALL have parameter IN_W, default 16, width of each lane.
REQ-003 SHALL have parameter SIGNED, default 0, 0 = unsigned lanes, 1 = two's-complement lanes.
REQ-004 SHALL have parameter ACC_W, default 32, accumulator/output width; ACC_W >= IN_W+log2(N_IN) (SIGNED: plus 1 not required, sign-extend).
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous flush of pipeline valids and accumulator.
REQ-008 in_valid  input  1  in_data/in_last qualify this cycle.
REQ-009 in_last  input  1  beat closes the current accumulation group.
REQ-010 in_data  input  N_IN*IN_W  packed lanes, lane k at bits [k*IN_W +: IN_W].
REQ-011 out_valid  output  1  one-cycle pulse, out_sum/out_ovf valid.
REQ-012 out_sum  output  ACC_W  group total, modulo 2^ACC_W.
REQ-013 out_ovf  output  1  group total exceeded ACC_W range.

Function
REQ-014 Tree SHALL have L = log2(N_IN) registered levels; level j adds pairs, result width IN_W+j+1, zero- or sign-extended per SIGNED.
REQ-015 valid, last SHALL travel with data through every level; no stall, one beat per cycle accepted.
REQ-016 Tree-stage output width IN_W+L SHALL be extended to ACC_W before accumulation, never truncated.
REQ-017 Accumulate stage: on tree-valid, if first beat of group acc <= tree_sum, else acc <= acc + tree_sum.
REQ-018 First-beat flag SHALL be set by reset, clr, and every consumed last beat; cleared by any non-last consumed beat.
REQ-019 When a consumed tree beat has last=1, out_sum SHALL equal that beat's accumulated value and out_valid SHALL pulse the following cycle; latency in_valid&in_last sample to out_valid = L+1 cycles.
REQ-020 out_sum, out_ovf SHALL hold their value between pulses.
REQ-021 Overflow: unsigned = carry out of ACC_W add; signed = operands same sign, result different sign; sticky within group, reset at group first beat, reported in out_ovf with out_valid.
REQ-022 Group of one beat (in_last on every beat) SHALL produce out_sum = plain tree sum each beat, back-to-back pulses.
REQ-023 clr SHALL zero all stage valids, acc, sticky ovf, set first flag; beats in flight dropped, no out_valid next cycle.
REQ-024 clr and in_valid same cycle: clr wins, beat discarded.
REQ-025 in_last without in_valid SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously zero all stage registers, valids, acc, out_sum, out_ovf, out_valid; set first flag.
REQ-027 Reset deassertion mid-group SHALL start a fresh group; no output from pre-reset beats.

Verification (N_IN=8, IN_W=16, ACC_W=32 unless stated)
REQ-028 Single beat, lanes 1..8, in_last=1 -> out_valid after 4 cycles, out_sum=36, out_ovf=0.
REQ-029 Three beats all lanes 0xFFFF, last on third -> out_sum=3*8*65535=1572840, one pulse, none earlier.
REQ-030 SIGNED=1, lanes -1 x8, one last beat -> out_sum=0xFFFFFFF8; lanes {-32768 x4, 32767 x4} -> out_sum=0xFFFFFFFC.
REQ-031 ACC_W=20, unsigned, two beats lanes 0xFFFF -> out_sum=1048560 mod 2^20 = 1048560, ovf=0; third beat -> out_sum=524264, out_ovf=1; next group ovf=0.
REQ-032 Continuous last beats every cycle with lane0=n, others 0 -> out_valid every cycle, out_sum=n in order.
REQ-033 Group in flight, clr pulsed 2 cycles after last beat -> no out_valid; next single beat lanes 1..8 -> out_sum=36; same test with rst_n pulse, async.

Source files
------------

// File: rtl/adder_tree_acc.sv
// Pipelined N_IN-lane adder tree feeding a group accumulator with sticky overflow.
// Each tree level is one register stage; valid/last ride alongside the data.
module adder_tree_acc #(
  parameter int N_IN   = 8,
  parameter int IN_W   = 16,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 out_valid,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 out_ovf
);

  localparam int   L  = $clog2(N_IN);
  localparam int   TW = IN_W + L;
  localparam logic SX = (SIGNED != 0);

  // Every node is carried at the final tree width; the extra top bits of the
  // shallow levels are pure zero/sign extension, so sums cannot wrap.
  logic [TW-1:0] leaf [N_IN];
  logic [TW-1:0] node [1:N_IN-1];

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_leaf
      assign leaf[gi] = {{L{SX & in_data[gi*IN_W+IN_W-1]}}, in_data[gi*IN_W +: IN_W]};
    end

    // Heap layout: node gi has children 2gi and 2gi+1; indices >= N_IN are lanes.
    for (gi = 1; gi < N_IN; gi++) begin : g_node
      if (2*gi >= N_IN) begin : g_from_leaf
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            node[gi] <= '0;
          end else begin
            node[gi] <= leaf[2*gi-N_IN] + leaf[2*gi+1-N_IN];
          end
        end
      end else begin : g_from_node
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            node[gi] <= '0;
          end else begin
            node[gi] <= node[2*gi] + node[2*gi+1];
          end
        end
      end
    end
  endgenerate

  logic [L:1] vld_reg;
  logic [L:1] lst_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      lst_reg <= '0;
    end else if (clr) begin
      vld_reg <= '0;
      lst_reg <= '0;
    end else begin
      vld_reg[1] <= in_valid;
      lst_reg[1] <= in_valid & in_last;
      for (int i = 2; i <= L; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        lst_reg[i] <= lst_reg[i-1];
      end
    end
  end

  logic [ACC_W-1:0] tree_ext;

  generate
    if (ACC_W > TW) begin : g_ext
      assign tree_ext = {{(ACC_W-TW){SX & node[1][TW-1]}}, node[1]};
    end else begin : g_noext
      assign tree_ext = node[1];
    end
  endgenerate

  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic             first_reg;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_now;
  logic             ovf_next;

  always_comb begin
    base     = first_reg ? '0 : acc_reg;
    sum_wide = {1'b0, base} + {1'b0, tree_ext};
    acc_next = sum_wide[ACC_W-1:0];
    if (SX) begin
      ovf_now = (base[ACC_W-1] == tree_ext[ACC_W-1]) && (acc_next[ACC_W-1] != base[ACC_W-1]);
    end else begin
      ovf_now = sum_wide[ACC_W];
    end
    ovf_next = (ovf_reg & ~first_reg) | ovf_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      first_reg <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        acc_reg   <= '0;
        ovf_reg   <= 1'b0;
        first_reg <= 1'b1;
      end else if (vld_reg[L]) begin
        acc_reg   <= acc_next;
        ovf_reg   <= ovf_next;
        first_reg <= lst_reg[L];
        if (lst_reg[L]) begin
          out_valid <= 1'b1;
          out_sum   <= acc_next;
          out_ovf   <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: unsigned 32-bit, signed 32-bit and unsigned 20-bit
// instances share one stimulus stream; each checks its own expected results.
module tb_adder_tree_acc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_last;
  logic [127:0] in_data;

  logic        v0, v1, v2, o0, o1, o2;
  logic [31:0] s0, s1;
  logic [19:0] s2;

  logic        ov [3];
  logic [31:0] os [3];
  logic        oo [3];

  assign ov[0] = v0;
  assign ov[1] = v1;
  assign ov[2] = v2;
  assign os[0] = s0;
  assign os[1] = s1;
  assign os[2] = {12'd0, s2};
  assign oo[0] = o0;
  assign oo[1] = o1;
  assign oo[2] = o2;

  always #5 clk = ~clk;

  adder_tree_acc #(.N_IN(8), .IN_W(16), .SIGNED(0), .ACC_W(32)) dut_u (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .out_valid(v0), .out_sum(s0), .out_ovf(o0));

  adder_tree_acc #(.N_IN(8), .IN_W(16), .SIGNED(1), .ACC_W(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .out_valid(v1), .out_sum(s1), .out_ovf(o1));

  adder_tree_acc #(.N_IN(8), .IN_W(16), .SIGNED(0), .ACC_W(20)) dut_n (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .out_valid(v2), .out_sum(s2), .out_ovf(o2));

  typedef struct {
    int           nb;
    logic [127:0] data;
    logic [31:0]  es [3];
    logic [2:0]   eovf;
  } vec_t;

  localparam logic [127:0] L18  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [127:0] ALLF = {8{16'hFFFF}};
  localparam logic [127:0] MIX  = {{4{16'h7FFF}}, {4{16'h8000}}};
  localparam logic [127:0] MAXP = {8{16'h7FFF}};

  int total = 0;
  int bad   = 0;
  vec_t tbl [8];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d] got=0x%0h want=0x%0h", nm, id, act, exp);
    end
  endtask

  // Drive a group of n beats back to back (last on the final one); the
  // closing pulse must appear exactly 4 cycles after the last beat is sampled.
  task automatic run_group(input int n, input logic [127:0] d, input logic [31:0] es [3],
                           input logic [2:0] eovf, input int id);
    for (int t = 0; t < n + 3; t++) begin
      in_valid = (t < n);
      in_last  = (t == n - 1);
      in_data  = d;
      @(negedge clk);
      if (t + 1 < n + 3) begin
        for (int k = 0; k < 3; k++) chk("early_valid", id*10+k, {31'd0, ov[k]}, 32'd0);
      end else begin
        for (int k = 0; k < 3; k++) begin
          chk("valid", id*10+k, {31'd0, ov[k]}, 32'd1);
          chk("sum",   id*10+k, os[k], es[k]);
          chk("ovf",   id*10+k, {31'd0, oo[k]}, {31'd0, eovf[k]});
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step(input logic v, input logic l, input logic c, input logic [127:0] d,
                      input logic quiet, input int id);
    in_valid = v;
    in_last  = l;
    clr      = c;
    in_data  = d;
    @(negedge clk);
    if (quiet) begin
      for (int k = 0; k < 3; k++) chk("no_pulse", id*10+k, {31'd0, ov[k]}, 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{nb: 1, data: L18,  es: '{32'd36, 32'd36, 32'd36}, eovf: 3'b000};
    tbl[1] = '{nb: 1, data: ALLF, es: '{32'd524280, 32'hFFFFFFF8, 32'd524280}, eovf: 3'b000};
    tbl[2] = '{nb: 1, data: MIX,  es: '{32'd262140, 32'hFFFFFFFC, 32'd262140}, eovf: 3'b000};
    tbl[3] = '{nb: 2, data: ALLF, es: '{32'd1048560, 32'hFFFFFFF0, 32'd1048560}, eovf: 3'b000};
    tbl[4] = '{nb: 3, data: ALLF, es: '{32'd1572840, 32'hFFFFFFE8, 32'd524264}, eovf: 3'b100};
    tbl[5] = '{nb: 1, data: ALLF, es: '{32'd524280, 32'hFFFFFFF8, 32'd524280}, eovf: 3'b000};
    tbl[6] = '{nb: 2, data: L18,  es: '{32'd72, 32'd72, 32'd72}, eovf: 3'b000};
    tbl[7] = '{nb: 1, data: MAXP, es: '{32'd262136, 32'd262136, 32'd262136}, eovf: 3'b000};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, {31'd0, ov[k]}, 32'd0);
      chk("rst_sum",   k, os[k], 32'd0);
      chk("rst_ovf",   k, {31'd0, oo[k]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_group(tbl[i].nb, tbl[i].data, tbl[i].es, tbl[i].eovf, i);
      $display("vector %0d beats=%0d sums=%0h/%0h/%0h ovf=%b%b%b", i, tbl[i].nb,
               os[0], os[1], os[2], oo[2], oo[1], oo[0]);
    end

    // One-beat groups every cycle: lane0 = n, pulses back to back.
    for (int t = 0; t < 13; t++) begin
      in_valid = (t < 10);
      in_last  = (t < 10);
      in_data  = {112'd0, 16'(t + 1)};
      @(negedge clk);
      if (t + 1 >= 4) begin
        chk("stream_valid", t, {31'd0, ov[0]}, 32'd1);
        chk("stream_sum",   t, os[0], 32'(t - 2));
        $display("stream beat %0d sum=%0d", t - 3, os[0]);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("hold_valid", 0, {31'd0, ov[0]}, 32'd0);
    chk("hold_sum",   0, os[0], 32'd10);

    // clr two cycles after the closing beat: that group must never emerge.
    step(1, 0, 0, L18, 1, 100);
    step(1, 0, 0, L18, 1, 101);
    step(1, 1, 0, L18, 1, 102);
    step(0, 0, 0, L18, 1, 103);
    step(0, 0, 1, L18, 1, 104);
    for (int i = 0; i < 5; i++) step(0, 0, 0, L18, 1, 105 + i);
    run_group(1, L18, '{32'd36, 32'd36, 32'd36}, 3'b000, 20);
    $display("after clr sum=%0d", os[0]);

    // clr and in_valid together: the beat is discarded.
    step(1, 1, 1, L18, 1, 110);
    for (int i = 0; i < 6; i++) step(0, 0, 0, L18, 1, 111 + i);
    $display("clr with valid, no pulse");

    // in_last without in_valid must not close the group.
    step(1, 0, 0, L18, 1, 120);
    step(0, 1, 0, L18, 1, 121);
    step(1, 1, 0, L18, 1, 122);
    step(0, 0, 0, L18, 1, 123);
    step(0, 0, 0, L18, 1, 124);
    step(0, 0, 0, L18, 0, 125);
    for (int k = 0; k < 3; k++) begin
      chk("lone_last_valid", k, {31'd0, ov[k]}, 32'd1);
      chk("lone_last_sum",   k, os[k], 32'd72);
    end
    $display("lone last ignored sum=%0d", os[0]);

    // Same as the clr case, but with an asynchronous reset pulse between edges.
    step(1, 0, 0, L18, 1, 130);
    step(1, 0, 0, L18, 1, 131);
    step(1, 1, 0, L18, 1, 132);
    step(0, 0, 0, L18, 1, 133);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_sum",   k, os[k], 32'd0);
      chk("async_valid", k, {31'd0, ov[k]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, L18, 1, 134 + i);
    run_group(1, L18, '{32'd36, 32'd36, 32'd36}, 3'b000, 30);
    $display("after async reset sum=%0d", os[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
